adc_quad_capture: RTL and testbench



---
 rtl/adc_quad_pkg.sv | 28 ++
 rtl/spi_frame_engine.sv | 91 +++++++++
 rtl/adc_quad_capture.sv | 162 ++++++++++++++++
 tb/tb_adc_quad_capture.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_quad_pkg.sv
// Shared constants, field positions and FSM encoding for the quad ADC capture engine.
package adc_quad_pkg;

  localparam int FRAME_LEN = 16;
  localparam int N_CH      = 4;
  localparam int SMP_W     = 12;

  // Control word: {start bit, two reserved zeros, addr[2:0], ten zeros}
  localparam logic [2:0] CTRL_HDR = 3'b100;

  // Returned word: {1'b0, tag[2:0], data[11:0]}
  localparam int HDR_BIT  = 15;
  localparam int TAG_MSB  = 14;
  localparam int TAG_LSB  = 12;
  localparam int DATA_MSB = 11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FRAME = 2'd1,
    ST_QUIET = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  function automatic logic [FRAME_LEN-1:0] ctrl_word(input logic [2:0] addr);
    return {CTRL_HDR, addr, 10'b0};
  endfunction

endpackage

// File: rtl/spi_frame_engine.sv
// One 16-bit full-duplex SPI frame: SCLK idles high, MOSI launched on falling
// edges (first bit presented as CS_N falls), MISO captured on rising edges.
module spi_frame_engine
  import adc_quad_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 go,
  input  logic [FRAME_LEN-1:0] tx_word,
  input  logic                 miso,
  output logic                 sclk,
  output logic                 cs_n,
  output logic                 mosi,
  output logic [FRAME_LEN-1:0] rx_word,
  output logic                 frame_done
);

  localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int EDGE_W = $clog2(2 * FRAME_LEN);
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(2 * FRAME_LEN - 1);

  logic                 active;
  logic [DIV_W-1:0]     div_cnt;
  logic [EDGE_W-1:0]    edge_cnt;
  logic [FRAME_LEN-2:0] tx_sr;
  logic [FRAME_LEN-2:0] rx_sr;
  logic                 tick;
  logic                 rise;
  logic                 fall_shift;

  // Even edge indices are falling edges, odd ones rising; the very first
  // falling edge launches the bit that is already on MOSI.
  assign tick       = active && (div_cnt == DIV_LAST);
  assign rise       = tick && edge_cnt[0];
  assign fall_shift = tick && !edge_cnt[0] && (edge_cnt != '0);
  assign frame_done = tick && (edge_cnt == EDGE_LAST);

  // The last bit is sampled on the same edge that ends the frame, so the
  // completed word includes the live MISO value.
  assign rx_word = {rx_sr, miso};

  // Frame control: chip select, SCLK divider and edge counter, MOSI launch
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      active   <= 1'b0;
      cs_n     <= 1'b1;
      sclk     <= 1'b1;
      mosi     <= 1'b0;
      div_cnt  <= '0;
      edge_cnt <= '0;
    end else if (go) begin
      active   <= 1'b1;
      cs_n     <= 1'b0;
      sclk     <= 1'b1;
      mosi     <= tx_word[FRAME_LEN-1];
      div_cnt  <= '0;
      edge_cnt <= '0;
    end else if (active) begin
      if (tick) begin
        div_cnt  <= '0;
        edge_cnt <= edge_cnt + 1'b1;
        sclk     <= ~sclk;
        if (fall_shift) begin
          mosi <= tx_sr[FRAME_LEN-2];
        end
        if (frame_done) begin
          active <= 1'b0;
          cs_n   <= 1'b1;
        end
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
    end
  end

  // Shift registers: transmit word shifted on falling edges, receive on rising
  always_ff @(posedge clk) begin
    if (go) begin
      tx_sr <= tx_word[FRAME_LEN-2:0];
    end else if (fall_shift) begin
      tx_sr <= {tx_sr[FRAME_LEN-3:0], 1'b0};
    end
    if (rise) begin
      rx_sr <= {rx_sr[FRAME_LEN-3:0], miso};
    end
  end

endmodule

// File: rtl/adc_quad_capture.sv
// Capture engine for the 4-channel current-sense ADC: five pipelined SPI frames
// per start, tag-checked shadow capture, and an atomic update of all four samples.
module adc_quad_capture
  import adc_quad_pkg::*;
#(
  parameter int CLK_DIV = 2,
  parameter int T_QUIET = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             sclk,
  output logic             cs_n,
  output logic             mosi,
  input  logic             miso,
  output logic [SMP_W-1:0] adc_a_pos,
  output logic [SMP_W-1:0] adc_a_neg,
  output logic [SMP_W-1:0] adc_b_pos,
  output logic [SMP_W-1:0] adc_b_neg,
  output logic             adc_rdy,
  output logic             adc_err,
  output logic             busy
);

  localparam int QW = (T_QUIET > 1) ? $clog2(T_QUIET) : 1;
  localparam logic [QW-1:0] Q_LAST     = QW'(T_QUIET - 1);
  localparam logic [2:0]    LAST_FRAME = 3'(N_CH);

  state_t                       state;
  state_t                       state_nxt;
  logic [2:0]                   fcnt;
  logic [QW-1:0]                qcnt;
  logic                         go;
  logic                         frame_done;
  logic [FRAME_LEN-1:0]         tx_word;
  logic [FRAME_LEN-1:0]         rx_word;
  logic                         frame_end;
  logic                         cap_en;
  logic                         last_frame;
  logic [1:0]                   cap_ch;
  logic [N_CH-1:0][SMP_W-1:0]   shd;
  logic [N_CH-1:0][SMP_W-1:0]   shd_nxt;
  logic [N_CH-1:0]              shd_ok;
  logic [N_CH-1:0]              ok_nxt;
  logic [N_CH-1:0][SMP_W-1:0]   samp;

  // Frame N+1 returns the conversion requested in frame N, so the final
  // request re-addresses channel 0 only to clock out channel 3.
  assign tx_word    = ctrl_word((fcnt == LAST_FRAME) ? 3'd0 : fcnt);
  assign frame_end  = (state == ST_FRAME) && frame_done;
  assign cap_en     = frame_end && (fcnt != 3'd0);
  assign last_frame = frame_end && (fcnt == LAST_FRAME);
  assign cap_ch     = 2'(fcnt - 3'd1);
  assign busy       = (state != ST_IDLE);

  assign adc_a_pos = samp[0];
  assign adc_a_neg = samp[1];
  assign adc_b_pos = samp[2];
  assign adc_b_neg = samp[3];

  spi_frame_engine #(
    .CLK_DIV(CLK_DIV)
  ) u_spi (
    .clk       (clk),
    .rst       (rst),
    .go        (go),
    .tx_word   (tx_word),
    .miso      (miso),
    .sclk      (sclk),
    .cs_n      (cs_n),
    .mosi      (mosi),
    .rx_word   (rx_word),
    .frame_done(frame_done)
  );

  // Sequencer next state and frame launch
  always_comb begin
    state_nxt = state;
    go        = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          go        = 1'b1;
          state_nxt = ST_FRAME;
        end
      end
      ST_FRAME: begin
        if (frame_done) begin
          state_nxt = (fcnt == LAST_FRAME) ? ST_DONE : ST_QUIET;
        end
      end
      ST_QUIET: begin
        if (qcnt == Q_LAST) begin
          go        = 1'b1;
          state_nxt = ST_FRAME;
        end
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Sequencer state, frame index and inter-frame quiet counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
      fcnt  <= 3'd0;
      qcnt  <= '0;
    end else begin
      state <= state_nxt;
      if ((state == ST_QUIET) && !go) begin
        qcnt <= qcnt + 1'b1;
      end else begin
        qcnt <= '0;
      end
      if (frame_end) begin
        fcnt <= (fcnt == LAST_FRAME) ? 3'd0 : fcnt + 3'd1;
      end
    end
  end

  // Shadow view including the word completing this cycle; a word is valid
  // only with a zero header bit and the tag of the channel it should carry.
  always_comb begin
    shd_nxt = shd;
    ok_nxt  = shd_ok;
    if (cap_en) begin
      shd_nxt[cap_ch] = rx_word[DATA_MSB:0];
      ok_nxt[cap_ch]  = (rx_word[HDR_BIT:TAG_LSB] == {2'b00, cap_ch});
    end
  end

  // Shadow registers, rewritten for every channel on each sequence
  always_ff @(posedge clk) begin
    shd    <= shd_nxt;
    shd_ok <= ok_nxt;
  end

  // Atomic output update and ready/error strobes as the last frame completes
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      samp    <= '0;
      adc_rdy <= 1'b0;
      adc_err <= 1'b0;
    end else begin
      adc_rdy <= last_frame;
      adc_err <= last_frame && !(&ok_nxt);
      if (last_frame) begin
        for (int i = 0; i < N_CH; i++) begin
          if (ok_nxt[i]) begin
            samp[i] <= shd_nxt[i];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_adc_quad_capture.sv
// Bench for adc_quad_capture: default-parameter and fast (CLK_DIV=1, T_QUIET=1)
// instances, a pipelined ADC model per instance, and a queue-based scoreboard.
module tb_adc_quad_capture;

  typedef struct {
    int          inst;
    int          cyc;
    logic [11:0] s0;
    logic [11:0] s1;
    logic [11:0] s2;
    logic [11:0] s3;
    logic        err;
  } rdy_exp_t;

  typedef struct {
    int          inst;
    logic [15:0] word;
  } frm_exp_t;

  logic        clk;
  logic        rst;
  logic [1:0]  start_w;
  logic [1:0]  sclk_w;
  logic [1:0]  cs_w;
  logic [1:0]  mosi_w;
  logic [1:0]  miso_w;
  logic [1:0]  rdy_w;
  logic [1:0]  err_w;
  logic [1:0]  busy_w;
  logic [11:0] a_pos_w [2];
  logic [11:0] a_neg_w [2];
  logic [11:0] b_pos_w [2];
  logic [11:0] b_neg_w [2];

  int cyc = 0;
  int n_chk = 0;
  int n_pass = 0;
  int err_frame = 7;
  logic [11:0] data_tbl [4];
  logic end_req = 1'b0;
  logic end_ack = 1'b0;

  rdy_exp_t exp_q [$];
  frm_exp_t frm_q [$];

  adc_quad_capture #(.CLK_DIV(2), .T_QUIET(4)) u_dut (
    .clk(clk), .rst(rst), .start(start_w[0]),
    .sclk(sclk_w[0]), .cs_n(cs_w[0]), .mosi(mosi_w[0]), .miso(miso_w[0]),
    .adc_a_pos(a_pos_w[0]), .adc_a_neg(a_neg_w[0]),
    .adc_b_pos(b_pos_w[0]), .adc_b_neg(b_neg_w[0]),
    .adc_rdy(rdy_w[0]), .adc_err(err_w[0]), .busy(busy_w[0])
  );

  adc_quad_capture #(.CLK_DIV(1), .T_QUIET(1)) u_fast (
    .clk(clk), .rst(rst), .start(start_w[1]),
    .sclk(sclk_w[1]), .cs_n(cs_w[1]), .mosi(mosi_w[1]), .miso(miso_w[1]),
    .adc_a_pos(a_pos_w[1]), .adc_a_neg(a_neg_w[1]),
    .adc_b_pos(b_pos_w[1]), .adc_b_neg(b_neg_w[1]),
    .adc_rdy(rdy_w[1]), .adc_err(err_w[1]), .busy(busy_w[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle number; stimulus changes at #1 after an edge, so "cycle N" is cyc==N
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int inst, input logic [31:0] act,
                     input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      $display("FAIL %s inst%0d @cyc %0d: got %0h, required %0h", name, inst, cyc, act, req);
    end else begin
      n_pass++;
    end
  endtask

  // ADC model + monitor: runs on the falling clock edge, away from DUT updates
  initial begin : monitor
    logic        prev_cs [2];
    logic        prev_sclk [2];
    logic        seen_rise [2];
    logic [15:0] tx_m [2];
    logic [15:0] rx_m [2];
    logic [2:0]  last_addr [2];
    logic        rdy_prev [2];
    int          fidx [2];
    logic [2:0]  tag;
    logic [15:0] mword;
    rdy_exp_t    e;
    frm_exp_t    fe;
    miso_w = 2'b00;
    for (int i = 0; i < 2; i++) begin
      prev_cs[i] = 1'b1; prev_sclk[i] = 1'b1; seen_rise[i] = 1'b0;
      tx_m[i] = '0; rx_m[i] = '0; last_addr[i] = 3'd0; rdy_prev[i] = 1'b0; fidx[i] = 0;
    end
    forever begin
      @(negedge clk);
      if (end_req && !end_ack) begin
        chk("pending_rdy", 0, exp_q.size(), 0);
        chk("pending_frames", 0, frm_q.size(), 0);
        end_ack = 1'b1;
      end
      for (int i = 0; i < 2; i++) begin
        if (!rst) begin
          chk("rst_sclk", i, sclk_w[i], 1);
          chk("rst_cs_n", i, cs_w[i], 1);
          chk("rst_mosi", i, mosi_w[i], 0);
          chk("rst_busy", i, busy_w[i], 0);
          chk("rst_rdy", i, rdy_w[i], 0);
          chk("rst_err", i, err_w[i], 0);
          chk("rst_samples", i, {a_pos_w[i], a_neg_w[i], b_pos_w[i][7:0]}, 0);
          chk("rst_b_samples", i, {b_pos_w[i][11:8], b_neg_w[i]}, 0);
          prev_cs[i] = 1'b1; prev_sclk[i] = 1'b1; seen_rise[i] = 1'b0;
          last_addr[i] = 3'd0; fidx[i] = 0; rdy_prev[i] = 1'b0; miso_w[i] = 1'b0;
        end else begin
          if (prev_cs[i] && !cs_w[i]) begin
            tag   = (fidx[i] == err_frame) ? 3'd5 : last_addr[i];
            mword = {1'b0, tag, data_tbl[last_addr[i][1:0]]};
            tx_m[i] = mword;
            miso_w[i] = mword[15];
            seen_rise[i] = 1'b0;
            rx_m[i] = '0;
          end
          if (!prev_sclk[i] && sclk_w[i]) begin
            rx_m[i] = {rx_m[i][14:0], mosi_w[i]};
            seen_rise[i] = 1'b1;
          end
          if (prev_sclk[i] && !sclk_w[i] && seen_rise[i]) begin
            tx_m[i] = {tx_m[i][14:0], 1'b0};
            miso_w[i] = tx_m[i][15];
          end
          if (!prev_cs[i] && cs_w[i]) begin
            if (frm_q.size() == 0) begin
              n_chk++;
              $display("FAIL frame_count inst%0d @cyc %0d: got an extra frame, required none", i, cyc);
            end else begin
              fe = frm_q.pop_front();
              chk("frame_inst", i, i, fe.inst);
              chk("mosi_word", i, rx_m[i], fe.word);
            end
            last_addr[i] = rx_m[i][12:10];
            fidx[i] = (fidx[i] == 4) ? 0 : fidx[i] + 1;
          end
          prev_cs[i]   = cs_w[i];
          prev_sclk[i] = sclk_w[i];

          if (rdy_prev[i]) chk("busy_after_done", i, busy_w[i], 0);
          if (err_w[i]) chk("err_needs_rdy", i, rdy_w[i], 1);
          if (rdy_w[i]) begin
            if (exp_q.size() == 0) begin
              n_chk++;
              $display("FAIL rdy_count inst%0d @cyc %0d: got an extra adc_rdy, required none", i, cyc);
            end else begin
              e = exp_q.pop_front();
              chk("rdy_inst", i, i, e.inst);
              chk("rdy_cycle", i, cyc, e.cyc);
              chk("busy_at_done", i, busy_w[i], 1);
              chk("a_pos", i, a_pos_w[i], e.s0);
              chk("a_neg", i, a_neg_w[i], e.s1);
              chk("b_pos", i, b_pos_w[i], e.s2);
              chk("b_neg", i, b_neg_w[i], e.s3);
              chk("adc_err", i, err_w[i], e.err);
            end
          end
          rdy_prev[i] = rdy_w[i];
        end
      end
    end
  end

  task automatic at(input int t);
    while (cyc < t) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_rdy(input int inst, input int c, input logic [11:0] s0,
                          input logic [11:0] s1, input logic [11:0] s2,
                          input logic [11:0] s3, input logic err);
    rdy_exp_t e;
    e.inst = inst; e.cyc = c; e.s0 = s0; e.s1 = s1; e.s2 = s2; e.s3 = s3; e.err = err;
    exp_q.push_back(e);
  endtask

  // Control words for addresses 0,1,2,3,0: {1,00,addr,10'b0}
  task automatic push_frames(input int inst, input int n);
    logic [15:0] w [5];
    frm_exp_t    fe;
    w = '{16'h8000, 16'h8400, 16'h8800, 16'h8C00, 16'h8000};
    for (int k = 0; k < n; k++) begin
      fe.inst = inst;
      fe.word = w[k];
      frm_q.push_back(fe);
    end
  endtask

  task automatic set_tbl(input logic [11:0] d0, input logic [11:0] d1,
                         input logic [11:0] d2, input logic [11:0] d3);
    data_tbl[0] = d0; data_tbl[1] = d1; data_tbl[2] = d2; data_tbl[3] = d3;
  endtask

  // Stimulus
  initial begin : stim
    int t0;
    int t2;
    int t3;
    int t4;
    rst = 1'b0;
    start_w = 2'b00;
    set_tbl(12'h123, 12'h456, 12'h789, 12'hABC);
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;

    // Nominal sequence, with starts at cycles 100 and 337 that must be dropped
    at(cyc + 3);
    t0 = cyc;
    start_w[0] = 1'b1;
    push_rdy(0, t0 + 337, 12'h123, 12'h456, 12'h789, 12'hABC, 1'b0);
    push_frames(0, 5);
    at(t0 + 1);   start_w[0] = 1'b0;
    at(t0 + 100); start_w[0] = 1'b1;
    at(t0 + 101); start_w[0] = 1'b0;
    at(t0 + 337); start_w[0] = 1'b1;

    // Start at cycle 338 is accepted; frame 2 returns a bad tag for channel 1
    at(t0 + 338);
    set_tbl(12'h0F1, 12'hE2D, 12'h5A5, 12'h3C3);
    err_frame = 2;
    push_rdy(0, t0 + 338 + 337, 12'h0F1, 12'h456, 12'h5A5, 12'h3C3, 1'b1);
    push_frames(0, 5);
    at(t0 + 339); start_w[0] = 1'b0;

    // Reset in the middle of frame 2: only frames 0 and 1 complete, no adc_rdy
    at(t0 + 680);
    t2 = cyc;
    err_frame = 7;
    set_tbl(12'h111, 12'h222, 12'h333, 12'h444);
    start_w[0] = 1'b1;
    push_frames(0, 2);
    at(t2 + 1);   start_w[0] = 1'b0;
    at(t2 + 150); rst = 1'b0;
    at(t2 + 153); rst = 1'b1;

    // Sequence after reset; channel 0 tag error shows its sample stayed cleared
    at(t2 + 160);
    t3 = cyc;
    set_tbl(12'h3A7, 12'h0C4, 12'hFFF, 12'h800);
    err_frame = 1;
    start_w[0] = 1'b1;
    push_rdy(0, t3 + 337, 12'h000, 12'h0C4, 12'hFFF, 12'h800, 1'b1);
    push_frames(0, 5);
    at(t3 + 1); start_w[0] = 1'b0;

    // Fast instance: CLK_DIV=1, T_QUIET=1 -> adc_rdy at cycle 165
    at(t3 + 345);
    t4 = cyc;
    err_frame = 7;
    set_tbl(12'h123, 12'h456, 12'h789, 12'hABC);
    start_w[1] = 1'b1;
    push_rdy(1, t4 + 165, 12'h123, 12'h456, 12'h789, 12'hABC, 1'b0);
    push_frames(1, 5);
    at(t4 + 1); start_w[1] = 1'b0;

    at(t4 + 180);
    end_req = 1'b1;
    repeat (5) @(posedge clk);
    if (!end_ack) begin
      $display("FAIL monitor_ack: got no acknowledge, required acknowledge");
      $fatal(1, "monitor did not respond");
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
